// File: rtl/id_hazard_scoreboard_if.sv
// Decode-side hazard interface for id_hazard_scoreboard.
//   master : decode stage (drives the instruction description, reads controls)
//   slave  : id_hazard_scoreboard (reads the instruction, drives controls)
// Signals:
//   id_valid/id_des/id_load  decode instruction, destination (0 = none), is-load
//   ra/rb, use_a/use_b       source indices and their read enables
//   syscall, flush           syscall in decode, taken jump/branch kill
//   stall, bubble            IF/ID hold, ID/EX clear
//   fwd_a/fwd_b              0 = regfile, k = forward from stage k
//   lu_stalls/sys_stalls     stall-cycle statistics (0 unless STALL_STATS_EN)
// SW must equal the SW of the attached scoreboard.
interface id_hazard_scoreboard_if #(
  parameter int unsigned RW = 5,
  parameter int unsigned SW = 2
);
  logic          id_valid;
  logic [RW-1:0] id_des;
  logic          id_load;
  logic [RW-1:0] ra;
  logic [RW-1:0] rb;
  logic          use_a;
  logic          use_b;
  logic          syscall;
  logic          flush;
  logic          stall;
  logic          bubble;
  logic [SW-1:0] fwd_a;
  logic [SW-1:0] fwd_b;
  logic [31:0]   lu_stalls;
  logic [31:0]   sys_stalls;

  modport master (
    output id_valid, id_des, id_load, ra, rb, use_a, use_b, syscall, flush,
    input  stall, bubble, fwd_a, fwd_b, lu_stalls, sys_stalls
  );

  modport slave (
    input  id_valid, id_des, id_load, ra, rb, use_a, use_b, syscall, flush,
    output stall, bubble, fwd_a, fwd_b, lu_stalls, sys_stalls
  );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard and forwarding controller.
// Tracks {valid, dest, load} of the instructions in EX..WB in a shadow pipe and
// derives stall/bubble, per-operand forwarding selects and a syscall drain FSM.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  id_hazard_scoreboard_if.slave (decode instruction in, controls out)
// Optional feature: define STALL_STATS_EN to build the saturating lu_stalls /
// sys_stalls counters; otherwise both outputs are tied to 0.
module id_hazard_scoreboard #(
  parameter int unsigned RW       = 5,
  parameter int unsigned STAGES   = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned SYS_RA   = 2,
  parameter int unsigned SYS_RB   = 4,
  parameter int unsigned SW       = $clog2(STAGES + 1)
) (
  input logic                   clk,
  input logic                   rst,
  id_hazard_scoreboard_if.slave bus
);

  typedef enum logic {StIdle, StDrain} state_e;

  localparam logic [RW-1:0] SysRa = RW'(SYS_RA);
  localparam logic [RW-1:0] SysRb = RW'(SYS_RB);

  // Shadow pipe; index k holds stage k+1. Load flags are only needed while a
  // load still cannot forward, so only LOAD_LAT of them are kept.
  logic [STAGES-1:0]   v_q;
  logic [RW-1:0]       des_q [STAGES];
  logic [LOAD_LAT-1:0] ld_q;

  logic [RW-1:0]     src_a, src_b;
  logic              use_a_eff, use_b_eff;
  logic [STAGES-1:0] match_a, match_b, match_sys;
  logic [SW-1:0]     fwd_a, fwd_b, drain_len;
  logic              lu_raw, lu, sys_hazard, sys_stall, stall;

  state_e        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;

  // Per-stage source matches; register 0 never matches.
  always_comb begin
    src_a     = bus.syscall ? SysRa : bus.ra;
    src_b     = bus.syscall ? SysRb : bus.rb;
    use_a_eff = bus.syscall | bus.use_a;
    use_b_eff = bus.syscall | bus.use_b;
    match_a   = '0;
    match_b   = '0;
    match_sys = '0;
    for (int k = 0; k < STAGES; k++) begin
      match_a[k]   = v_q[k] && (des_q[k] != '0) && (des_q[k] == src_a) && use_a_eff;
      match_b[k]   = v_q[k] && (des_q[k] != '0) && (des_q[k] == src_b) && use_b_eff;
      match_sys[k] = v_q[k] && (des_q[k] != '0) && ((des_q[k] == SysRa) || (des_q[k] == SysRb));
    end
  end

  // Oldest-to-youngest scan so the youngest producer wins the select.
  always_comb begin
    fwd_a     = '0;
    fwd_b     = '0;
    drain_len = '0;
    lu_raw    = 1'b0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      if (match_a[k])   fwd_a = SW'(k + 1);
      if (match_b[k])   fwd_b = SW'(k + 1);
      // Cycles until the youngest producer has left WB: STAGES + 1 - kmin.
      if (match_sys[k]) drain_len = SW'(int'(STAGES) - k);
    end
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (ld_q[k] && (match_a[k] || match_b[k])) lu_raw = 1'b1;
    end
    // Syscalls read their operands only after the drain, never via bypass.
    if (bus.syscall) begin
      fwd_a = '0;
      fwd_b = '0;
    end
  end

  assign sys_hazard = bus.syscall && bus.id_valid && !bus.flush && (|match_sys);

  // Syscall drain FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Syscall drain FSM: next state. The IDLE cycle is the first stall cycle, so
  // DRAIN covers the remaining drain_len - 1 cycles and leaves once the
  // decremented count reaches 1. A one-cycle drain never enters DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (sys_hazard) begin
          cnt_d = drain_len;
          if (drain_len > SW'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (bus.flush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - SW'(1);
          if (cnt_d == SW'(1)) state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Syscall drain FSM and hazard outputs; flush overrides every stall source.
  always_comb begin
    sys_stall = 1'b0;
    unique case (state_q)
      StIdle:  sys_stall = sys_hazard;
      StDrain: sys_stall = !bus.flush;
      default: sys_stall = 1'b0;
    endcase
    lu    = lu_raw && !bus.flush;
    stall = lu || sys_stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      ld_q <= '0;
      for (int k = 0; k < STAGES; k++) des_q[k] <= '0;
    end else begin
      v_q[0]   <= bus.id_valid && !stall && !bus.flush;
      des_q[0] <= bus.id_des;
      ld_q[0]  <= bus.id_load;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k]   <= v_q[k-1];
        des_q[k] <= des_q[k-1];
      end
      for (int k = 1; k < LOAD_LAT; k++) ld_q[k] <= ld_q[k-1];
    end
  end

  assign bus.stall  = stall;
  assign bus.bubble = stall || bus.flush;
  assign bus.fwd_a  = fwd_a;
  assign bus.fwd_b  = fwd_b;

`ifdef STALL_STATS_EN
  logic [31:0] lu_cnt_q, sys_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q  <= '0;
      sys_cnt_q <= '0;
    end else begin
      if (lu && (lu_cnt_q != '1))         lu_cnt_q  <= lu_cnt_q + 32'd1;
      if (sys_stall && (sys_cnt_q != '1)) sys_cnt_q <= sys_cnt_q + 32'd1;
    end
  end

  assign bus.lu_stalls  = lu_cnt_q;
  assign bus.sys_stalls = sys_cnt_q;
`else
  assign bus.lu_stalls  = '0;
  assign bus.sys_stalls = '0;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
module tb_id_hazard_scoreboard;
  localparam int unsigned RW     = 5;
  localparam int unsigned STAGES = 3;
  localparam int unsigned SW     = 2;

`ifdef STALL_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  id_hazard_scoreboard_if #(.RW(RW), .SW(SW)) bus ();

  id_hazard_scoreboard #(
    .RW      (RW),
    .STAGES  (STAGES),
    .LOAD_LAT(1),
    .SYS_RA  (2),
    .SYS_RB  (4),
    .SW      (SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat(input int n);
    return Stats ? 32'(n) : 32'd0;
  endfunction

  task automatic drive(input logic v, input logic [4:0] des, input logic ld,
                       input logic [4:0] a, input logic [4:0] b, input logic ua,
                       input logic ub, input logic sys, input logic fl);
    bus.id_valid = v;
    bus.id_des   = des;
    bus.id_load  = ld;
    bus.ra       = a;
    bus.rb       = b;
    bus.use_a    = ua;
    bus.use_b    = ub;
    bus.syscall  = sys;
    bus.flush    = fl;
  endtask

  // Inputs change on the falling edge; checks run 1 time unit later.
  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_stall", bus.stall, 0);
    check_eq("rst_bubble", bus.bubble, 0);
    check_eq("rst_fwd_a", bus.fwd_a, 0);
    check_eq("rst_fwd_b", bus.fwd_b, 0);
    check_eq("rst_lu_cnt", bus.lu_stalls, 0);
    check_eq("rst_sys_cnt", bus.sys_stalls, 0);
    @(negedge clk);

    // Back-to-back dependency
    drive(1, 8, 0, 0, 0, 0, 0, 0, 0);
    #1 check_eq("b2b_issue_stall", bus.stall, 0);
    @(negedge clk);
    drive(1, 0, 0, 8, 8, 1, 1, 0, 0);
    #1;
    check_eq("b2b_fwd_a1", bus.fwd_a, 1);
    check_eq("b2b_fwd_b1", bus.fwd_b, 1);
    check_eq("b2b_stall", bus.stall, 0);
    @(negedge clk);
    drive(1, 0, 0, 8, 0, 1, 0, 0, 0);
    #1 check_eq("b2b_fwd_a2", bus.fwd_a, 2);
    @(negedge clk);
    idle(3);

    // Load-use
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 5, 0, 1, 0, 0);
    #1;
    check_eq("lu_stall", bus.stall, 1);
    check_eq("lu_bubble", bus.bubble, 1);
    check_eq("lu_fwd_b1", bus.fwd_b, 1);
    @(negedge clk);
    #1;
    check_eq("lu_release_stall", bus.stall, 0);
    check_eq("lu_release_bubble", bus.bubble, 0);
    check_eq("lu_fwd_b2", bus.fwd_b, 2);
    check_eq("lu_cnt", bus.lu_stalls, stat(1));
    @(negedge clk);
    idle(3);

    // Syscall drain, producer in stage 1 -> 3 stall cycles
    drive(1, 2, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("sys_stall_%0d", i), bus.stall, 1);
      check_eq($sformatf("sys_fwd_a_%0d", i), bus.fwd_a, 0);
      check_eq($sformatf("sys_fwd_b_%0d", i), bus.fwd_b, 0);
      @(negedge clk);
    end
    #1;
    check_eq("sys_release_stall", bus.stall, 0);
    check_eq("sys_cnt3", bus.sys_stalls, stat(3));
    @(negedge clk);
    idle(3);

    // Syscall drain, producer in stage 2 -> 2 stall cycles
    drive(1, 4, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      #1 check_eq($sformatf("sys2_stall_%0d", i), bus.stall, 1);
      @(negedge clk);
    end
    #1;
    check_eq("sys2_release_stall", bus.stall, 0);
    check_eq("sys_cnt5", bus.sys_stalls, stat(5));
    @(negedge clk);
    idle(3);

    // Flush during DRAIN releases immediately
    drive(1, 2, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    #1 check_eq("dflush_first_stall", bus.stall, 1);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    check_eq("dflush_stall", bus.stall, 0);
    check_eq("dflush_bubble", bus.bubble, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_eq("dflush_idle_stall", bus.stall, 0);
    check_eq("sys_cnt6", bus.sys_stalls, stat(6));
    @(negedge clk);
    idle(3);

    // Register 0
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
    #1;
    check_eq("r0_stall", bus.stall, 0);
    check_eq("r0_fwd_a", bus.fwd_a, 0);
    @(negedge clk);
    idle(3);

    // Flush priority: flushed instruction also writes r7, so a valid stage 1
    // would show up as fwd_a=1 on the next cycle.
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 7, 0, 7, 0, 1, 0, 0, 1);
    #1;
    check_eq("flush_stall", bus.stall, 0);
    check_eq("flush_bubble", bus.bubble, 1);
    @(negedge clk);
    drive(1, 0, 0, 7, 0, 1, 0, 0, 0);
    #1;
    check_eq("flush_s1_invalid_fwd", bus.fwd_a, 2);
    check_eq("flush_next_stall", bus.stall, 0);
    check_eq("flush_lu_cnt", bus.lu_stalls, stat(1));
    @(negedge clk);
    idle(3);

    // Reset mid-drain
    drive(1, 4, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    #1 check_eq("rd_idle_stall", bus.stall, 1);
    @(negedge clk);
    #1 check_eq("rd_drain_stall", bus.stall, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 4, 4, 1, 1, 0, 0);
    #1;
    check_eq("rd_stall", bus.stall, 0);
    check_eq("rd_fwd_a", bus.fwd_a, 0);
    check_eq("rd_fwd_b", bus.fwd_b, 0);
    check_eq("rd_lu_cnt", bus.lu_stalls, 0);
    check_eq("rd_sys_cnt", bus.sys_stalls, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    #1 check_eq("rd_sys_nomatch_stall", bus.stall, 0);
    @(negedge clk);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
